// File: rtl/conv_core_kxk_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_core_kxk_if
// Purpose  : Operand/result valid-ready bundle for the KxK convolution core.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_core_kxk_if #(
  parameter int K      = 3,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [K*K*DATA_W-1:0]   image;
  logic [K*K*DATA_W-1:0]   filter;
  logic                    signed_mode;
  logic                    relu_en;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        conv_out;
  logic                    sat;

  modport slave (
    input  in_valid, image, filter, signed_mode, relu_en, out_ready,
    output in_ready, out_valid, conv_out, sat
  );

  modport master (
    output in_valid, image, filter, signed_mode, relu_en, out_ready,
    input  in_ready, out_valid, conv_out, sat
  );
endinterface
`default_nettype wire

// File: rtl/conv_core_kxk.sv
`default_nettype none
// ============================================================================
// Module   : conv_core_kxk
// Purpose  : KxK window dot product on one shared multiplier, signed or
//            unsigned operands, optional ReLU and saturating output.
// Revision : 1.0 - initial release
// ============================================================================
module conv_core_kxk #(
  parameter int K      = 3,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  conv_core_kxk_if.slave  bus
);
  localparam int N      = K * K;
  localparam int ACC_W  = 2 * DATA_W + $clog2(N) + 1;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int PROD_W = 2 * DATA_W + 2;

  localparam logic [ACC_W:0]   c_one  = 1;
  localparam logic [ACC_W-1:0] c_umax = ACC_W'((c_one << OUT_W) - c_one);
  localparam logic [ACC_W-1:0] c_smax = ACC_W'((c_one << (OUT_W - 1)) - c_one);
  localparam logic [ACC_W-1:0] c_smin = ~c_smax;
  localparam logic [IDX_W-1:0] c_last = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_in_ready;
  logic [N*DATA_W-1:0]   r_image;
  logic [N*DATA_W-1:0]   r_filter;
  logic                  r_signed;
  logic                  r_relu;
  logic [ACC_W-1:0]      r_acc;
  logic [IDX_W-1:0]      r_idx;
  logic [OUT_W-1:0]      r_conv_out;
  logic                  r_sat;

  logic                  w_accept;
  logic [DATA_W-1:0]     w_img_e;
  logic [DATA_W-1:0]     w_flt_e;
  logic signed [DATA_W:0] w_a;
  logic signed [DATA_W:0] w_b;
  logic signed [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]      w_prod_ext;
  logic [ACC_W-1:0]      w_acc_sum;
  logic [ACC_W-1:0]      w_r;
  logic [OUT_W-1:0]      w_res;
  logic                  w_res_sat;

  assign w_accept = (r_state == S_IDLE) && bus.in_valid && r_in_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_MAC;
      S_MAC:   if (r_idx == c_last) w_next = S_OUT;
      S_OUT:   if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // in_ready is registered from the next state so it stays low through reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == S_IDLE);
    end
  end

  // One extra sign bit turns both operand modes into a single signed multiply
  assign w_img_e    = r_image[r_idx*DATA_W +: DATA_W];
  assign w_flt_e    = r_filter[r_idx*DATA_W +: DATA_W];
  assign w_a        = {r_signed & w_img_e[DATA_W-1], w_img_e};
  assign w_b        = {r_signed & w_flt_e[DATA_W-1], w_flt_e};
  assign w_prod     = w_a * w_b;
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_acc_sum  = r_acc + w_prod_ext;

  always_comb begin
    w_r = w_acc_sum;
    if (r_relu && r_signed && w_r[ACC_W-1]) w_r = '0;
    w_res     = w_r[OUT_W-1:0];
    w_res_sat = 1'b0;
    if (r_signed) begin
      if ($signed(w_r) > $signed(c_smax)) begin
        w_res     = c_smax[OUT_W-1:0];
        w_res_sat = 1'b1;
      end else if ($signed(w_r) < $signed(c_smin)) begin
        w_res     = c_smin[OUT_W-1:0];
        w_res_sat = 1'b1;
      end
    end else if (w_r > c_umax) begin
      w_res     = c_umax[OUT_W-1:0];
      w_res_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_image    <= '0;
      r_filter   <= '0;
      r_signed   <= 1'b0;
      r_relu     <= 1'b0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_conv_out <= '0;
      r_sat      <= 1'b0;
    end else if (w_accept) begin
      r_image  <= bus.image;
      r_filter <= bus.filter;
      r_signed <= bus.signed_mode;
      r_relu   <= bus.relu_en;
      r_acc    <= '0;
      r_idx    <= '0;
    end else if (r_state == S_MAC) begin
      r_acc <= w_acc_sum;
      r_idx <= r_idx + 1'b1;
      if (r_idx == c_last) begin
        r_conv_out <= w_res;
        r_sat      <= w_res_sat;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.conv_out  = r_conv_out;
  assign bus.sat       = r_sat;
endmodule
`default_nettype wire
